// File: rtl/udp_40g_pkg.sv
// Shared types and widths for the udp_40G_TOP link supervision logic.
package udp_40g_pkg;

  typedef enum logic [2:0] {
    RST_HOLD   = 3'd0,
    GT_WAIT    = 3'd1,
    ALIGN_WAIT = 3'd2,
    LINK_UP    = 3'd3
  } link_state_t;

  localparam int LINK_RETRY_W = 8;
  localparam int LINK_STAT_W  = 16;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mac40g_link_ctrl.sv
// Bring-up and supervision sequencer for one 40G MAC/GT port; outputs decode from the next state.
// Optional LINK_CTRL_STATS_EN adds link_drop_cnt and up_time_cnt outputs.
module mac40g_link_ctrl
  import udp_40g_pkg::*;
#(
  parameter int RESET_CYCLES  = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int ALIGN_TIMEOUT = 262144,
  parameter int ALIGN_STABLE  = 256
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset_n,
  input  logic                    enable,
  input  logic                    force_reset,
  input  logic                    gt_locked,
  input  logic                    rx_aligned,
  output logic                    gt_reset,
  output logic                    mac_reset,
  output logic                    ctl_rx_enable,
  output logic                    ctl_tx_enable,
  output logic                    ctl_tx_send_rfi,
  output logic                    link_up,
  output logic [2:0]              state,
  output logic [LINK_RETRY_W-1:0] retry_cnt
`ifdef LINK_CTRL_STATS_EN
  ,
  output logic [LINK_STAT_W-1:0]  link_drop_cnt,
  output logic [31:0]             up_time_cnt
`endif
);

  localparam int MAX_A  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B  = (ALIGN_TIMEOUT > ALIGN_STABLE) ? ALIGN_TIMEOUT : ALIGN_STABLE;
  localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAX_P);
  localparam int STB_W  = $clog2(ALIGN_STABLE + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_DONE   = STB_W'(ALIGN_STABLE);

  link_state_t      cur;
  link_state_t      nxt;
  logic [CNT_W-1:0] cnt;
  logic [STB_W-1:0] stable_cnt;
  logic             lock_s;
  logic             align_s;
  logic             restart;
  logic             timeout;

  sync_2ff u_sync_lock (
    .clk   (sys_clk),
    .rst_n (sys_reset_n),
    .d     (gt_locked),
    .q     (lock_s)
  );

  sync_2ff u_sync_align (
    .clk   (sys_clk),
    .rst_n (sys_reset_n),
    .d     (rx_aligned),
    .q     (align_s)
  );

  assign restart = !enable || force_reset;
  assign state   = cur;

  always_comb begin
    nxt     = cur;
    timeout = 1'b0;
    if (restart) begin
      nxt = RST_HOLD;
    end else if (!lock_s && (cur == ALIGN_WAIT || cur == LINK_UP)) begin
      nxt = RST_HOLD;
    end else begin
      unique case (cur)
        RST_HOLD: begin
          if (cnt == RST_LAST) nxt = GT_WAIT;
        end
        GT_WAIT: begin
          if (lock_s) begin
            nxt = ALIGN_WAIT;
          end else if (cnt == LOCK_LAST) begin
            nxt     = RST_HOLD;
            timeout = 1'b1;
          end
        end
        // Stable completion is checked first so it beats a coincident timeout.
        ALIGN_WAIT: begin
          if (stable_cnt == STB_DONE) begin
            nxt = LINK_UP;
          end else if (cnt == ALIGN_LAST) begin
            nxt     = RST_HOLD;
            timeout = 1'b1;
          end
        end
        LINK_UP: begin
          if (!align_s) nxt = ALIGN_WAIT;
        end
        default: nxt = RST_HOLD;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cur             <= RST_HOLD;
      cnt             <= '0;
      stable_cnt      <= '0;
      retry_cnt       <= '0;
      gt_reset        <= 1'b1;
      mac_reset       <= 1'b1;
      ctl_rx_enable   <= 1'b0;
      ctl_tx_enable   <= 1'b0;
      ctl_tx_send_rfi <= 1'b0;
      link_up         <= 1'b0;
    end else begin
      cur <= nxt;

      if (nxt != cur || restart || cur == LINK_UP) cnt <= '0;
      else                                         cnt <= cnt + 1'b1;

      if (nxt != cur || cur != ALIGN_WAIT || !align_s) stable_cnt <= '0;
      else if (stable_cnt != STB_DONE)                 stable_cnt <= stable_cnt + 1'b1;

      if (timeout && retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;

      gt_reset        <= (nxt == RST_HOLD);
      mac_reset       <= (nxt == RST_HOLD) || (nxt == GT_WAIT);
      ctl_rx_enable   <= (nxt == ALIGN_WAIT) || (nxt == LINK_UP);
      ctl_tx_enable   <= (nxt == LINK_UP);
      ctl_tx_send_rfi <= (nxt == ALIGN_WAIT);
      link_up         <= (nxt == LINK_UP);
    end
  end

`ifdef LINK_CTRL_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      link_drop_cnt <= '0;
      up_time_cnt   <= '0;
    end else begin
      if (cur == LINK_UP && nxt != LINK_UP && link_drop_cnt != '1)
        link_drop_cnt <= link_drop_cnt + 1'b1;
      if (nxt == LINK_UP && cur != LINK_UP)
        up_time_cnt <= '0;
      else if (cur == LINK_UP && up_time_cnt != '1)
        up_time_cnt <= up_time_cnt + 1'b1;
    end
  end
`endif

endmodule
